// File: rtl/bounce_sprite_overlay.sv
// Bouncing sprite overlay: draws a ROM-backed sprite over a background fill and moves it
// diagonally once per divided frame, clamping and reflecting at the screen edges.
module bounce_sprite_overlay #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          SPR_W     = 100,
    parameter int          SPR_H     = 125,
    parameter int          ADDR_W    = 14,
    parameter int          STEP      = 1,
    parameter int          X0        = 430,
    parameter int          Y0        = 50,
    parameter bit          TRANSP_EN = 1'b1,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [9:0]        h_cnt_i,
    input  logic [9:0]        v_cnt_i,
    input  logic              enable_i,
    input  logic [7:0]        frame_div_i,
    input  logic [23:0]       bg_color_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [11:0]       rom_data_i,
    output logic [23:0]       vga_data_o,
    output logic [9:0]        pos_x_o,
    output logic [9:0]        pos_y_o,
    output logic              dir_x_o,
    output logic              dir_y_o,
    output logic              bounce_o,
    output logic              corner_o
);

    localparam logic [9:0]  MAXX    = 10'(H_RES - SPR_W);
    localparam logic [9:0]  MAXY    = 10'(V_RES - SPR_H);
    localparam logic [9:0]  STEP10  = 10'(STEP);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);

    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              bounce_q, bounce_d;
    logic              corner_q, corner_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              valid_q, hit_q;
    logic [23:0]       vga_data_q, vga_data_d;

    logic [10:0] h_w, v_w, px_w, py_w, dx_w, dy_w;
    logic        hit;
    logic        tick, step_en;
    logic [7:0]  div_last;
    logic        refl_x, refl_y;
    logic [11:0] x_next, y_next;
    logic [23:0] rgb888;
    logic        key_hit;

    // Result packed as {reflect, dir_next, pos_next}; 11-bit compares keep pos+STEP from wrapping.
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] lim);
        logic [11:0] res;
        logic [10:0] p;
        p = {1'b0, pos};
        if (!dir) begin
            if (p + STEP11 >= {1'b0, lim})
                res = {1'b1, 1'b1, lim};
            else
                res = {1'b0, 1'b0, pos + STEP10};
        end else begin
            if (p <= STEP11)
                res = {1'b1, 1'b0, 10'd0};
            else
                res = {1'b0, 1'b1, pos - STEP10};
        end
        return res;
    endfunction

    assign h_w  = {1'b0, h_cnt_i};
    assign v_w  = {1'b0, v_cnt_i};
    assign px_w = {1'b0, pos_x_q};
    assign py_w = {1'b0, pos_y_q};
    assign dx_w = h_w - px_w;
    assign dy_w = v_w - py_w;

    assign hit = valid_i
               && (h_w >= px_w) && (h_w < px_w + SPR_W11)
               && (v_w >= py_w) && (v_w < py_w + SPR_H11);

    // Row-major address straight from the counters, so blanking layout never skews it.
    assign rom_addr_d = hit ? ADDR_W'({11'd0, dy_w} * 22'(SPR_W) + {11'd0, dx_w}) : '0;

    assign tick     = (h_cnt_i == 10'd0) && (v_cnt_i == 10'(V_RES));
    assign div_last = (frame_div_i == 8'd0) ? 8'd0 : frame_div_i - 8'd1;
    assign step_en  = tick && enable_i && (fcnt_q >= div_last);

    assign x_next = axis_step(pos_x_q, dir_x_q, MAXX);
    assign y_next = axis_step(pos_y_q, dir_y_q, MAXY);

    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        refl_x   = 1'b0;
        refl_y   = 1'b0;
        fcnt_d   = fcnt_q;
        if (tick && enable_i) begin
            if (step_en) begin
                fcnt_d  = 8'd0;
                pos_x_d = x_next[9:0];
                dir_x_d = x_next[10];
                refl_x  = x_next[11];
                pos_y_d = y_next[9:0];
                dir_y_d = y_next[10];
                refl_y  = y_next[11];
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
        bounce_d = refl_x | refl_y;
        corner_d = refl_x & refl_y;
    end

    // Stage 2 works on rom_data_i, which belongs to the address registered last cycle.
    assign rgb888  = {rom_data_i[11:8], rom_data_i[11:8],
                      rom_data_i[7:4],  rom_data_i[7:4],
                      rom_data_i[3:0],  rom_data_i[3:0]};
    assign key_hit = TRANSP_EN && (rom_data_i == KEY_COLOR);

    always_comb begin
        vga_data_d = 24'h000000;
        if (valid_q) begin
            if (!hit_q || key_hit)
                vga_data_d = bg_color_i;
            else
                vga_data_d = rgb888;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pos_x_q    <= 10'(X0);
            pos_y_q    <= 10'(Y0);
            dir_x_q    <= 1'b0;
            dir_y_q    <= 1'b0;
            fcnt_q     <= 8'd0;
            bounce_q   <= 1'b0;
            corner_q   <= 1'b0;
            rom_addr_q <= '0;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            vga_data_q <= 24'h000000;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            fcnt_q     <= fcnt_d;
            bounce_q   <= bounce_d;
            corner_q   <= corner_d;
            rom_addr_q <= rom_addr_d;
            valid_q    <= valid_i;
            hit_q      <= hit;
            vga_data_q <= vga_data_d;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign vga_data_o = vga_data_q;
    assign pos_x_o    = pos_x_q;
    assign pos_y_o    = pos_y_q;
    assign dir_x_o    = dir_x_q;
    assign dir_y_o    = dir_y_q;
    assign bounce_o   = bounce_q;
    assign corner_o   = corner_q;

endmodule

// File: tb/tb_bounce_sprite_overlay.sv
// Bench for bounce_sprite_overlay: two instances (default, and STEP=4 near the corner with
// transparency off) compared every cycle against a frame/pixel reference model.
module tb_bounce_sprite_overlay;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int SPR_W = 100;
    localparam int SPR_H = 125;
    localparam logic [11:0] KEY = 12'h0F0;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst, valid, enable;
    logic [9:0]  h_cnt, v_cnt;
    logic [7:0]  frame_div;
    logic [23:0] bg_color;

    logic [13:0] rom_addr0, rom_addr1;
    logic [11:0] rom_data0, rom_data1;
    logic [23:0] vga0, vga1;
    logic [9:0]  px0, py0, px1, py1;
    logic        dx0, dy0, dx1, dy1, b0, b1, c0, c1;

    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] rom_fn(input int a);
        if (a == 201) return 12'hA5C;
        if (a == 202) return KEY;
        return 12'(a ^ 32'h5A3);
    endfunction

    function automatic logic [23:0] expand(input logic [11:0] c);
        int r, g, b;
        r = int'(c[11:8]);
        g = int'(c[7:4]);
        b = int'(c[3:0]);
        return 24'(r * 17 * 65536 + g * 17 * 256 + b * 17);
    endfunction

    assign rom_data0 = rom_fn(int'(rom_addr0));
    assign rom_data1 = rom_fn(int'(rom_addr1));

    bounce_sprite_overlay #(
        .H_RES(H_RES), .V_RES(V_RES), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(14),
        .STEP(1), .X0(430), .Y0(50), .TRANSP_EN(1'b1), .KEY_COLOR(KEY)
    ) dut0 (
        .pclk(pclk), .rst(rst), .valid_i(valid), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt),
        .enable_i(enable), .frame_div_i(frame_div), .bg_color_i(bg_color),
        .rom_addr_o(rom_addr0), .rom_data_i(rom_data0), .vga_data_o(vga0),
        .pos_x_o(px0), .pos_y_o(py0), .dir_x_o(dx0), .dir_y_o(dy0),
        .bounce_o(b0), .corner_o(c0)
    );

    bounce_sprite_overlay #(
        .H_RES(H_RES), .V_RES(V_RES), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(14),
        .STEP(4), .X0(538), .Y0(353), .TRANSP_EN(1'b0), .KEY_COLOR(KEY)
    ) dut1 (
        .pclk(pclk), .rst(rst), .valid_i(valid), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt),
        .enable_i(enable), .frame_div_i(frame_div), .bg_color_i(bg_color),
        .rom_addr_o(rom_addr1), .rom_data_i(rom_data1), .vga_data_o(vga1),
        .pos_x_o(px1), .pos_y_o(py1), .dir_x_o(dx1), .dir_y_o(dy1),
        .bounce_o(b1), .corner_o(c1)
    );

    // Reference model state, one slot per instance.
    int stp[2] = '{1, 4};
    bit tr[2]  = '{1'b1, 1'b0};
    int x0[2]  = '{430, 538};
    int y0[2]  = '{50, 353};
    int m_px[2], m_py[2], m_dx[2], m_dy[2], m_fcnt[2], m_b[2], m_c[2];
    int e_addr[2], e_v1[2], e_hit1[2];
    logic [23:0] e_vga[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void move(input int p, input int d, input int s, input int mx,
                                 output int np, output int nd, output int r);
        r = 0;
        if (d == 0) begin
            np = p + s;
            nd = 0;
            if (np >= mx) begin np = mx; nd = 1; r = 1; end
        end else begin
            np = p - s;
            nd = 1;
            if (np <= 0) begin np = 0; nd = 0; r = 1; end
        end
    endfunction

    task automatic model_edge();
        bit tick;
        int h, v, div, nx, ndx, rx, ny, ndy, ry, hit, addr;
        logic [11:0] rd;
        logic [23:0] nv;
        h = int'(h_cnt);
        v = int'(v_cnt);
        tick = (h == 0) && (v == V_RES);
        for (int k = 0; k < 2; k++) begin
            if (rst === 1'b1) begin
                m_px[k] = x0[k]; m_py[k] = y0[k]; m_dx[k] = 0; m_dy[k] = 0;
                m_fcnt[k] = 0; m_b[k] = 0; m_c[k] = 0;
                e_addr[k] = 0; e_v1[k] = 0; e_hit1[k] = 0; e_vga[k] = 24'h0;
            end else begin
                rd = rom_fn(e_addr[k]);
                if (e_v1[k] == 0) nv = 24'h0;
                else if (e_hit1[k] == 0 || (tr[k] && rd == KEY)) nv = bg_color;
                else nv = expand(rd);
                hit = (valid === 1'b1 && h >= m_px[k] && h < m_px[k] + SPR_W &&
                       v >= m_py[k] && v < m_py[k] + SPR_H) ? 1 : 0;
                addr = (hit != 0) ? (v - m_py[k]) * SPR_W + (h - m_px[k]) : 0;
                e_vga[k] = nv;
                e_v1[k] = (valid === 1'b1) ? 1 : 0;
                e_hit1[k] = hit;
                e_addr[k] = addr;
                m_b[k] = 0;
                m_c[k] = 0;
                if (tick && enable === 1'b1) begin
                    div = (frame_div == 8'd0) ? 1 : int'(frame_div);
                    if (m_fcnt[k] >= div - 1) begin
                        m_fcnt[k] = 0;
                        move(m_px[k], m_dx[k], stp[k], H_RES - SPR_W, nx, ndx, rx);
                        move(m_py[k], m_dy[k], stp[k], V_RES - SPR_H, ny, ndy, ry);
                        m_px[k] = nx; m_dx[k] = ndx;
                        m_py[k] = ny; m_dy[k] = ndy;
                        m_b[k] = (rx != 0 || ry != 0) ? 1 : 0;
                        m_c[k] = (rx != 0 && ry != 0) ? 1 : 0;
                    end else begin
                        m_fcnt[k]++;
                    end
                end
            end
        end
    endtask

    task automatic cmp_inst(input int k, input logic [13:0] ra, input logic [23:0] vd,
                            input logic [9:0] px, input logic [9:0] py, input logic dx,
                            input logic dy, input logic b, input logic c);
        chk($sformatf("i%0d pos_x", k), 32'(px), 32'(m_px[k]));
        chk($sformatf("i%0d pos_y", k), 32'(py), 32'(m_py[k]));
        chk($sformatf("i%0d dir_x", k), 32'(dx), 32'(m_dx[k]));
        chk($sformatf("i%0d dir_y", k), 32'(dy), 32'(m_dy[k]));
        chk($sformatf("i%0d bounce", k), 32'(b), 32'(m_b[k]));
        chk($sformatf("i%0d corner", k), 32'(c), 32'(m_c[k]));
        chk($sformatf("i%0d rom_addr", k), 32'(ra), 32'(e_addr[k]));
        chk($sformatf("i%0d vga_data", k), 32'(vd), 32'(e_vga[k]));
    endtask

    task automatic clk1();
        @(posedge pclk);
        model_edge();
        #1;
        cmp_inst(0, rom_addr0, vga0, px0, py0, dx0, dy0, b0, c0);
        cmp_inst(1, rom_addr1, vga1, px1, py1, dx1, dy1, b1, c1);
    endtask

    task automatic set_tick();
        valid = 1'b0; h_cnt = 10'd0; v_cnt = 10'(V_RES);
    endtask

    task automatic frame_tick();
        set_tick();
        clk1();
        v_cnt = 10'd0; h_cnt = 10'd5;
        clk1();
    endtask

    typedef struct {
        logic        vld;
        int          h;
        int          v;
        logic [23:0] bg;
        int          a0;
        logic [23:0] g0;
        int          a1;
        logic [23:0] g1;
    } vec_t;

    vec_t tbl[15];
    int r;

    initial begin
        tbl[0]  = '{1'b1, 431, 52,  24'h102030, 201,   24'hAA55CC, 0, 24'h102030};
        tbl[1]  = '{1'b1, 0,   0,   24'h102030, 0,     24'h102030, 0, 24'h102030};
        tbl[2]  = '{1'b0, 431, 52,  24'h102030, 0,     24'h000000, 0, 24'h000000};
        tbl[3]  = '{1'b1, 432, 52,  24'h123456, 202,   24'h123456, 0, 24'h123456};
        tbl[4]  = '{1'b1, 540, 355, 24'h123456, 0,     24'h123456, 202, 24'h00FF00};
        tbl[5]  = '{1'b1, 539, 355, 24'h123456, 0,     24'h123456, 201, 24'hAA55CC};
        tbl[6]  = '{1'b1, 430, 50,  24'h0A0B0C, 0,     expand(rom_fn(0)), 0, 24'h0A0B0C};
        tbl[7]  = '{1'b1, 529, 174, 24'h0A0B0C, 12499, expand(rom_fn(12499)), 0, 24'h0A0B0C};
        tbl[8]  = '{1'b1, 530, 174, 24'h0A0B0C, 0,     24'h0A0B0C, 0, 24'h0A0B0C};
        tbl[9]  = '{1'b1, 429, 100, 24'h0A0B0C, 0,     24'h0A0B0C, 0, 24'h0A0B0C};
        tbl[10] = '{1'b1, 430, 175, 24'h0A0B0C, 0,     24'h0A0B0C, 0, 24'h0A0B0C};
        tbl[11] = '{1'b1, 637, 477, 24'h0A0B0C, 0,     24'h0A0B0C, 12499, expand(rom_fn(12499))};
        tbl[12] = '{1'b1, 638, 477, 24'h0A0B0C, 0,     24'h0A0B0C, 0, 24'h0A0B0C};
        tbl[13] = '{1'b1, 537, 400, 24'h0A0B0C, 0,     24'h0A0B0C, 0, 24'h0A0B0C};
        tbl[14] = '{1'b1, 538, 478, 24'h0A0B0C, 0,     24'h0A0B0C, 0, 24'h0A0B0C};

        rst = 1'b1; valid = 1'b0; enable = 1'b0; frame_div = 8'd1;
        h_cnt = 10'd0; v_cnt = 10'd0; bg_color = 24'h0;
        repeat (3) clk1();
        chk("reset pos_x", 32'(px0), 32'd430);
        chk("reset pos_y", 32'(py0), 32'd50);
        chk("reset dirs", 32'({dx0, dy0}), 32'd0);
        chk("reset vga_data", 32'(vga0), 32'd0);
        chk("reset rom_addr", 32'(rom_addr0), 32'd0);
        chk("reset i1 pos", 32'({px1, py1}), 32'({10'd538, 10'd353}));
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            valid = tbl[i].vld; h_cnt = 10'(tbl[i].h); v_cnt = 10'(tbl[i].v);
            bg_color = tbl[i].bg;
            clk1();
            chk($sformatf("vec%0d addr0", i), 32'(rom_addr0), 32'(tbl[i].a0));
            chk($sformatf("vec%0d addr1", i), 32'(rom_addr1), 32'(tbl[i].a1));
            clk1();
            chk($sformatf("vec%0d vga0", i), 32'(vga0), 32'(tbl[i].g0));
            chk($sformatf("vec%0d vga1", i), 32'(vga1), 32'(tbl[i].g1));
        end

        // Divide by 3: 430, 430, 431; third tick also drives instance 1 into the corner.
        enable = 1'b1; frame_div = 8'd3;
        frame_tick();
        chk("div3 tick1 pos_x", 32'(px0), 32'd430);
        frame_tick();
        chk("div3 tick2 pos_x", 32'(px0), 32'd430);
        set_tick();
        clk1();
        chk("div3 tick3 pos_x", 32'(px0), 32'd431);
        chk("div3 tick3 pos_y", 32'(py0), 32'd51);
        chk("corner pos", 32'({px1, py1}), 32'({10'd540, 10'd355}));
        chk("corner dirs", 32'({dx1, dy1}), 32'd3);
        chk("corner bounce", 32'(b1), 32'd1);
        chk("corner pulse", 32'(c1), 32'd1);
        chk("no bounce i0", 32'(b0), 32'd0);
        v_cnt = 10'd0; h_cnt = 10'd5;
        clk1();
        chk("corner bounce drop", 32'(b1), 32'd0);
        chk("corner pulse drop", 32'(c1), 32'd0);

        frame_div = 8'd0;
        frame_tick();
        chk("div0 tick1 pos_x", 32'(px0), 32'd432);
        frame_tick();
        chk("div0 tick2 pos_x", 32'(px0), 32'd433);

        enable = 1'b0;
        repeat (5) frame_tick();
        chk("pause pos_x", 32'(px0), 32'd433);
        chk("pause pos_y", 32'(py0), 32'd53);

        enable = 1'b1; rst = 1'b1;
        set_tick();
        clk1();
        chk("rst over tick pos_x", 32'(px0), 32'd430);
        chk("rst over tick i1 pos_x", 32'(px1), 32'd538);
        rst = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            r = int'($urandom_range(0, 99));
            rst = ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0;
            if (r < 12) begin
                set_tick();
            end else if (r < 55) begin
                valid = 1'b1;
                h_cnt = 10'(m_px[0] - 2 + int'($urandom_range(0, SPR_W + 3)));
                v_cnt = 10'(m_py[0] - 2 + int'($urandom_range(0, SPR_H + 3)));
            end else if (r < 75) begin
                valid = 1'b1;
                h_cnt = 10'(m_px[1] - 2 + int'($urandom_range(0, SPR_W + 3)));
                v_cnt = 10'(m_py[1] - 2 + int'($urandom_range(0, SPR_H + 3)));
            end else begin
                valid = 1'($urandom_range(0, 1));
                h_cnt = 10'($urandom_range(0, 1023));
                v_cnt = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 49) == 0) frame_div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) bg_color = 24'($urandom);
            clk1();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bounce_sprite_overlay.md
# bounce_sprite_overlay

Parametrised bouncing-sprite overlay for the VGA path. It draws an SPR_W x SPR_H sprite, fetched from an external synchronous ROM, at a position that moves diagonally and reflects off the screen edges, with the background filled elsewhere. It sits between the VGA timing generator, which supplies h_cnt, v_cnt and valid, and the 24-bit RGB output. Over the fixed-size logo mover it adds a programmable step size and frame-rate divider, clamped reflections, a colour-key transparency mode, pause control and bounce status pulses.

## Interface
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- SPR_W, 100: sprite width in pixels.
- SPR_H, 125: sprite height in lines.
- ADDR_W, 14: ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- STEP, 1: pixels moved per axis per motion step; 1..15.
- X0, 430 / Y0, 50: reset position (top-left corner of the sprite).
- TRANSP_EN, 1: enables colour-key transparency.
- KEY_COLOR, 12'h0F0: transparent ROM pixel value.
- pclk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- valid  in  1  active-video flag, aligned with h_cnt/v_cnt.
- h_cnt  in  10  horizontal counter.
- v_cnt  in  10  vertical counter.
- enable  in  1  1 = motion runs; 0 = position frozen.
- frame_div  in  8  frames per motion step; 0 is treated as 1.
- bg_color  in  24  background RGB888.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  12  RGB444 ROM pixel; valid one cycle after rom_addr.
- vga_data  out  24  RGB888 pixel.
- pos_x  out  10  current sprite x.
- pos_y  out  10  current sprite y.
- dir_x  out  1  x direction: 0 = +, 1 = -.
- dir_y  out  1  y direction: 0 = +, 1 = -.
- bounce  out  1  1-cycle pulse on any reflection.
- corner  out  1  1-cycle pulse when both axes reflect in the same step.

## Operation
- **In-sprite test (combinational):** `hit` = valid & h_cnt in [pos_x, pos_x+SPR_W-1] & v_cnt in [pos_y, pos_y+SPR_H-1].
- **ROM address:** (v_cnt-pos_y)*SPR_W + (h_cnt-pos_x), computed only when `hit`; otherwise 0.
  - Row-major, no incremental counter; this order is exact regardless of blanking layout.
- **Colour expansion:** RGB444 to RGB888 by nibble replication ({r,r},{g,g},{b,b}).
- **Output select, using the `hit`/valid values delayed to match rom_data:**
  - not valid: 24'h000000.
  - valid and not hit: bg_color.
  - hit, TRANSP_EN=1 and rom_data==KEY_COLOR: bg_color.
  - otherwise: the expanded rom_data.
- **Frame tick:** 1-cycle internal strobe when h_cnt==0 and v_cnt==V_RES, i.e. the first blanking line. Position therefore changes only during vertical blanking (no tearing).
- **Frame divider:** 8-bit fcnt.
  - On a tick with enable=1: if fcnt >= max(frame_div,1)-1, then fcnt<=0 and one motion step is taken; else fcnt++.
  - enable=0 holds fcnt and position.
- **Motion step, per axis** (x shown; y is identical with V_RES/SPR_H), MAXX = H_RES-SPR_W:
  - dir_x=0 and pos_x+STEP >= MAXX: pos_x<=MAXX, dir_x<=1, reflect.
  - dir_x=1 and pos_x <= STEP: pos_x<=0, dir_x<=0, reflect.
  - otherwise: pos_x <= pos_x ± STEP.
  - All arithmetic is 11-bit unsigned, so there is no wrap-around.
- **Status pulses:** bounce=1 for the cycle after a step in which either axis reflected. corner=1 in that same cycle only if both axes reflected.
- **Reset values:**
  - pos_x=X0, pos_y=Y0, dir_x=0, dir_y=0.
  - fcnt=0, rom_addr=0, vga_data=0, bounce=0, corner=0.
  - Pipeline valid/hit delay registers are 0.
  - Reset mid-frame takes effect on the next edge; output is black until the pipeline refills.

## Timing
- **Pixel pipeline:** h_cnt/v_cnt/valid presented in cycle n.
  - rom_addr and delay stage 1 registered at the end of n.
  - rom_data valid in n+1; vga_data registered at the end of n+1.
  - Total latency: 2 pclk from counters to vga_data. The timing generator delays sync by 2 to match.
- **Motion:** pos_x, pos_y, dir_x, dir_y update at the end of the frame-tick cycle. bounce/corner are asserted in the following cycle.
- **enable:** enable falling in the tick cycle suppresses that step.
- **frame_div:** changes are sampled at each tick.
- **Simultaneous events:** a tick coinciding with rst is ignored (rst wins).

## Test plan
- **Reset:** rst for 3 cycles -> pos=(430,50), dirs=0, vga_data=0, rom_addr=0.
- **Pixel fetch:** pos=(430,50), h=431, v=52, valid=1 -> rom_addr=2*100+1=201 one cycle later. rom_data=12'hA5C -> vga_data=24'hAA55CC two cycles after counters.
- **Background and blanking:**
  - h=0, v=0, valid=1, bg_color=24'h102030 -> vga_data=24'h102030.
  - valid=0 -> vga_data=0.
- **Transparency:** rom_data=12'h0F0 inside sprite, bg_color=24'h123456 -> vga_data=24'h123456.
  - With TRANSP_EN=0 -> 24'h00FF00.
- **Divider and pause:**
  - frame_div=3 -> pos_x advances 1 every third tick (430, 430, 431).
  - frame_div=0 -> advances every tick.
  - enable=0 for 5 ticks -> pos unchanged.
- **Clamp and corner:** STEP=4, pos_x=538, dir_x=0 -> after one step pos_x=540, dir_x=1, bounce pulse.
  - Start at (538,353) with dirs=0 -> pos=(540,355), both dirs=1, bounce=1 and corner=1 for exactly one cycle.
